// File: rtl/wfg_stim_ramp_pkg.sv
// -----------------------------------------------------------------------------
// wfg_stim_ramp_pkg
// Shared constants and types for the ramp stimulus source: register offsets
// (word index taken from wbs_adr_i[3:2]), CTRL bit positions, reset values,
// the ramp mode and FSM state enums, and the config bundle the register file
// hands to the ramp engine.
// -----------------------------------------------------------------------------
package wfg_stim_ramp_pkg;

  localparam logic [1:0] REG_CTRL = 2'h0;
  localparam logic [1:0] REG_INC  = 2'h1;
  localparam logic [1:0] REG_MIN  = 2'h2;
  localparam logic [1:0] REG_MAX  = 2'h3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;
  localparam int CTRL_CNT_LSB  = 16;

  localparam logic [31:0] RST_CTRL = 32'h0000_0000;
  localparam logic [31:0] RST_INC  = 32'h0000_0001;
  localparam logic [31:0] RST_MIN  = 32'h0000_0000;
  localparam logic [31:0] RST_MAX  = 32'hFFFF_FFFF;

  typedef enum logic {
    RAMP_SAW = 1'b0,
    RAMP_TRI = 1'b1
  } ramp_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ramp_state_e;

  typedef struct packed {
    logic        en;
    ramp_mode_e  mode;
    logic [31:0] inc;
    logic [31:0] min;
    logic [31:0] max;
  } ramp_cfg_t;

endpackage

// File: rtl/wfg_stim_ramp.sv
// -----------------------------------------------------------------------------
// wfg_stim_ramp
// Ramp engine: IDLE/RUN FSM, next-value datapath and AXIS-style output.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | output idle, tvalid=0, tdata=0, direction up
// ST_RUN  | streaming; tdata advances on each tvalid&tready handshake
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   cfg_i              config bundle (EN, MODE, INC, MIN, MAX)
//   tready_i           downstream ready
//   tvalid_o, tdata_o  sample stream
//   sample_cnt_o       accepted-sample count (only with
//                      WFG_STIM_RAMP_SAMPLE_CNT_EN defined)
// -----------------------------------------------------------------------------
module wfg_stim_ramp
  import wfg_stim_ramp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  ramp_cfg_t   cfg_i,
  input  logic        tready_i,
  output logic        tvalid_o,
  output logic [31:0] tdata_o
`ifdef WFG_STIM_RAMP_SAMPLE_CNT_EN
  ,output logic [15:0] sample_cnt_o
`endif
);

  ramp_state_e state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        dir_dn_q, dir_dn_d;

  logic [31:0] next_val;
  logic        next_dir_dn;
  logic [32:0] sum_up;
  logic [32:0] floor_dn;

  // 33-bit intermediates so neither the up-sum nor the down floor can wrap.
  always_comb begin
    sum_up      = {1'b0, data_q} + {1'b0, cfg_i.inc};
    floor_dn    = {1'b0, cfg_i.min} + {1'b0, cfg_i.inc};
    next_val    = cfg_i.min;
    next_dir_dn = 1'b0;
    if ((cfg_i.inc == 32'd0) || (cfg_i.min >= cfg_i.max)) begin
      next_val    = cfg_i.min;
      next_dir_dn = 1'b0;
    end else if (!dir_dn_q || (cfg_i.mode == RAMP_SAW)) begin
      // Sawtooth always counts up, which also clears a stale down direction.
      if (sum_up <= {1'b0, cfg_i.max}) begin
        next_val = sum_up[31:0];
      end else if (cfg_i.mode == RAMP_TRI) begin
        next_val    = cfg_i.max;
        next_dir_dn = 1'b1;
      end else begin
        next_val = cfg_i.min;
      end
    end else begin
      if ({1'b0, data_q} < floor_dn) begin
        next_val    = cfg_i.min;
        next_dir_dn = 1'b0;
      end else begin
        next_val    = data_q - cfg_i.inc;
        next_dir_dn = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dir_dn_d = dir_dn_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_i.en) begin
          state_d  = ST_RUN;
          data_d   = cfg_i.min;
          dir_dn_d = 1'b0;
        end
      end
      ST_RUN: begin
        // Abort wins over a pending handshake: no new sample is presented.
        if (!cfg_i.en) begin
          state_d  = ST_IDLE;
          data_d   = 32'd0;
          dir_dn_d = 1'b0;
        end else if (tready_i) begin
          data_d   = next_val;
          dir_dn_d = next_dir_dn;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        data_d   = 32'd0;
        dir_dn_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      data_q   <= 32'd0;
      dir_dn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      dir_dn_q <= dir_dn_d;
    end
  end

  assign tvalid_o = (state_q == ST_RUN);
  assign tdata_o  = data_q;

`ifdef WFG_STIM_RAMP_SAMPLE_CNT_EN
  logic [15:0] cnt_q;

  // A handshake in the same cycle as an abort still counts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 16'd0;
    end else if ((state_q == ST_IDLE) && cfg_i.en) begin
      cnt_q <= 16'd0;
    end else if (tvalid_o && tready_i) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign sample_cnt_o = cnt_q;
`endif

endmodule

// File: rtl/wfg_stim_ramp_top.sv
// -----------------------------------------------------------------------------
// wfg_stim_ramp_top
// Ramp stimulus source for the waveform generator: Wishbone register file
// (CTRL/INC/MIN/MAX) with single-cycle registered ack, feeding the ramp
// engine that streams samples on the AXIS-style stimulus port.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i    Wishbone request (stb already page-qualified)
//   wbs_sel_i               ignored, full-word access only
//   wbs_adr_i               byte offset, bits [3:2] decoded
//   wbs_dat_i/wbs_dat_o     write / registered read data
//   wbs_ack_o               one-cycle acknowledge
//   wfg_axis_tready_i       downstream ready
//   wfg_axis_tvalid_o/tdata_o sample stream
//
// Optional: define WFG_STIM_RAMP_SAMPLE_CNT_EN to expose a 16-bit accepted
// sample counter at CTRL[31:16].
// -----------------------------------------------------------------------------
module wfg_stim_ramp_top
  import wfg_stim_ramp_pkg::*;
#(
  parameter int BUSW = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [BUSW-1:0] wbs_dat_i,
  input  logic [BUSW-1:0] wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [BUSW-1:0] wbs_dat_o,
  input  logic            wfg_axis_tready_i,
  output logic            wfg_axis_tvalid_o,
  output logic [31:0]     wfg_axis_tdata_o
);

  logic            ack_q, ack_d;
  logic [BUSW-1:0] dat_q, dat_d;
  logic            en_q, en_d;
  ramp_mode_e      mode_q, mode_d;
  logic [31:0]     inc_q, inc_d;
  logic [31:0]     min_q, min_d;
  logic [31:0]     max_q, max_d;

  logic            access;
  logic [1:0]      reg_sel;
  logic [15:0]     cnt_rd;
  ramp_cfg_t       cfg;

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[BUSW-1:4], wbs_adr_i[1:0]};

  // Blocking on ack_q forces a one-cycle gap between back-to-back accesses.
  assign access  = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign reg_sel = wbs_adr_i[3:2];

  always_comb begin
    ack_d  = access;
    dat_d  = '0;
    en_d   = en_q;
    mode_d = mode_q;
    inc_d  = inc_q;
    min_d  = min_q;
    max_d  = max_q;
    if (access) begin
      if (wbs_we_i) begin
        case (reg_sel)
          REG_CTRL: begin
            en_d   = wbs_dat_i[CTRL_EN_BIT];
            mode_d = ramp_mode_e'(wbs_dat_i[CTRL_MODE_BIT]);
          end
          REG_INC: inc_d = wbs_dat_i;
          REG_MIN: min_d = wbs_dat_i;
          default: max_d = wbs_dat_i;
        endcase
      end else begin
        case (reg_sel)
          REG_CTRL: dat_d = {cnt_rd, 14'd0, mode_q, en_q};
          REG_INC:  dat_d = inc_q;
          REG_MIN:  dat_d = min_q;
          default:  dat_d = max_q;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      en_q   <= RST_CTRL[CTRL_EN_BIT];
      mode_q <= ramp_mode_e'(RST_CTRL[CTRL_MODE_BIT]);
      inc_q  <= RST_INC;
      min_q  <= RST_MIN;
      max_q  <= RST_MAX;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      inc_q  <= inc_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  assign cfg.en   = en_q;
  assign cfg.mode = mode_q;
  assign cfg.inc  = inc_q;
  assign cfg.min  = min_q;
  assign cfg.max  = max_q;

  wfg_stim_ramp u_ramp (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .cfg_i        (cfg),
    .tready_i     (wfg_axis_tready_i),
    .tvalid_o     (wfg_axis_tvalid_o),
    .tdata_o      (wfg_axis_tdata_o)
`ifdef WFG_STIM_RAMP_SAMPLE_CNT_EN
    ,.sample_cnt_o (cnt_rd)
`endif
  );

`ifndef WFG_STIM_RAMP_SAMPLE_CNT_EN
  assign cnt_rd = 16'd0;
`endif

endmodule

// File: tb/tb_wfg_stim_ramp_top.sv
module tb_wfg_stim_ramp_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic        tready;
  logic        tvalid;
  logic [31:0] tdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wfg_stim_ramp_top #(.BUSW(32)) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (rst),
    .wbs_stb_i         (stb),
    .wbs_cyc_i         (cyc),
    .wbs_we_i          (we),
    .wbs_sel_i         (sel),
    .wbs_dat_i         (dat_i),
    .wbs_adr_i         (adr),
    .wbs_ack_o         (ack),
    .wbs_dat_o         (dat_o),
    .wfg_axis_tready_i (tready),
    .wfg_axis_tvalid_o (tvalid),
    .wfg_axis_tdata_o  (tdata)
  );

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } bus_vec_t;

  typedef struct {
    logic             mode;
    logic [31:0]      min;
    logic [31:0]      max;
    logic [31:0]      inc;
    logic [7:0][31:0] exp;
  } stream_vec_t;

  bus_vec_t    bv[12];
  stream_vec_t sv[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one access; stb stays high one extra cycle to prove ack is a single pulse.
  task automatic wb(input logic w, input logic [3:0] a, input logic [31:0] wd,
                    output logic [31:0] rd);
    stb = 1'b1; cyc = 1'b1; we = w; adr = {28'd0, a}; dat_i = wd;
    @(posedge clk); #1;
    check("ack_high", {31'd0, ack}, 32'd1);
    rd = dat_o;
    @(posedge clk); #1;
    check("ack_low_next", {31'd0, ack}, 32'd0);
    check("dat_zero_no_ack", dat_o, 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  function automatic logic [7:0][31:0] seq8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  logic [31:0] rd;
  logic [31:0] exp_v;
  int          accepted;

  initial begin
    bv[0]  = '{1'b0, 4'h0, 32'h0,          32'h0000_0000};
    bv[1]  = '{1'b0, 4'h4, 32'h0,          32'h0000_0001};
    bv[2]  = '{1'b0, 4'h8, 32'h0,          32'h0000_0000};
    bv[3]  = '{1'b0, 4'hC, 32'h0,          32'hFFFF_FFFF};
    bv[4]  = '{1'b1, 4'h4, 32'h1234_5678,  32'h0};
    bv[5]  = '{1'b0, 4'h4, 32'h0,          32'h1234_5678};
    bv[6]  = '{1'b1, 4'h8, 32'h0000_00A5,  32'h0};
    bv[7]  = '{1'b0, 4'h8, 32'h0,          32'h0000_00A5};
    bv[8]  = '{1'b1, 4'hC, 32'h0000_0055,  32'h0};
    bv[9]  = '{1'b0, 4'hC, 32'h0,          32'h0000_0055};
    bv[10] = '{1'b1, 4'h0, 32'hFFFF_FFFC,  32'h0};
    bv[11] = '{1'b0, 4'h0, 32'h0,          32'h0000_0000};

    sv[0] = '{1'b0, 32'd10, 32'd20, 32'd4, seq8(10, 14, 18, 10, 14, 18, 10, 14)};
    sv[1] = '{1'b1, 32'd10, 32'd20, 32'd4, seq8(10, 14, 18, 20, 16, 12, 10, 14)};
    sv[2] = '{1'b1, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000,
              seq8(32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                   32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF)};
    sv[3] = '{1'b0, 32'd5, 32'd9, 32'd0, seq8(5, 5, 5, 5, 5, 5, 5, 5)};
    sv[4] = '{1'b1, 32'd9, 32'd9, 32'd3, seq8(9, 9, 9, 9, 9, 9, 9, 9)};
    sv[5] = '{1'b0, 32'd0, 32'hFFFF_FFFF, 32'hC000_0000,
              seq8(32'h0, 32'hC000_0000, 32'h0, 32'hC000_0000,
                   32'h0, 32'hC000_0000, 32'h0, 32'hC000_0000)};

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
    dat_i = '0; adr = '0; tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tdata", tdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      wb(bv[i].we, bv[i].adr, bv[i].wd, rd);
      if (!bv[i].we) check($sformatf("reg_rd[%0d]", i), rd, bv[i].exp);
    end

    tready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      wb(1'b1, 4'h0, 32'h0, rd);
      check($sformatf("s%0d_off_valid", t), {31'd0, tvalid}, 32'd0);
      check($sformatf("s%0d_off_data", t), tdata, 32'd0);
      wb(1'b1, 4'h4, sv[t].inc, rd);
      wb(1'b1, 4'h8, sv[t].min, rd);
      wb(1'b1, 4'hC, sv[t].max, rd);
      wb(1'b1, 4'h0, {30'd0, sv[t].mode, 1'b1}, rd);
      for (int k = 0; k < 8; k++) begin
        check($sformatf("s%0d_valid[%0d]", t, k), {31'd0, tvalid}, 32'd1);
        check($sformatf("s%0d_data[%0d]", t, k), tdata, sv[t].exp[k]);
        @(posedge clk); #1;
      end
    end

    // Random stalls, sawtooth 0..7
    tready = 1'b0;
    wb(1'b1, 4'h0, 32'h0, rd);
    wb(1'b1, 4'h4, 32'd1, rd);
    wb(1'b1, 4'h8, 32'd0, rd);
    wb(1'b1, 4'hC, 32'd7, rd);
    wb(1'b1, 4'h0, 32'd1, rd);
    exp_v = 0; accepted = 0;
    for (int c = 0; c < 300 && accepted < 9; c++) begin
      check("stall_valid", {31'd0, tvalid}, 32'd1);
      check("stall_data", tdata, exp_v);
      tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (tready) begin
        accepted++;
        exp_v = (exp_v == 32'd7) ? 32'd0 : exp_v + 32'd1;
      end
    end
    tready = 1'b0;
    check("stall_accept_count", accepted, 32'd9);
    repeat (2) begin
      @(posedge clk); #1;
      check("stall_hold_data", tdata, exp_v);
      check("stall_hold_valid", {31'd0, tvalid}, 32'd1);
    end
    wb(1'b0, 4'h0, 32'h0, rd);
`ifdef WFG_STIM_RAMP_SAMPLE_CNT_EN
    check("cnt_accepted", {16'd0, rd[31:16]}, accepted);
    check("cnt_ctrl_low", {30'd0, rd[1:0]}, 32'd1);
`else
    check("ctrl_run_rd", rd, 32'd1);
`endif
    wb(1'b1, 4'h0, 32'h0, rd);
    check("abort_valid", {31'd0, tvalid}, 32'd0);
    check("abort_data", tdata, 32'd0);
    wb(1'b1, 4'h0, 32'd1, rd);
    check("reen_valid", {31'd0, tvalid}, 32'd1);
    check("reen_data", tdata, 32'd0);
    wb(1'b0, 4'h0, 32'h0, rd);
`ifdef WFG_STIM_RAMP_SAMPLE_CNT_EN
    check("cnt_reen_zero", {16'd0, rd[31:16]}, 32'd0);
`else
    check("ctrl_reen_rd", rd, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
